// File: rtl/tt_scan_pkg.sv
// Shared types and defaults for the truth-table scanner.
//   state_e     : scanner FSM states
//   DEF_N_IN    : default number of function inputs
//   DEF_SETTLE  : default settle clocks before sampling F
//   tt_depth()  : table depth for a given input count (2**n)
package tt_scan_pkg;

   localparam int unsigned DEF_N_IN   = 3;
   localparam int unsigned DEF_SETTLE = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_e;

   function automatic int unsigned tt_depth(input int unsigned n);
      return 32'd1 << n;
   endfunction

endpackage

// File: rtl/settle_timer.sv
// Load / count-down timer with a zero flag, used to space input application and sampling.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   load        : load load_val this cycle (takes priority over counting)
//   load_val    : value to load
//   zero_c      : combinational flag, counter currently at zero
module settle_timer #(
   parameter int unsigned CW = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   output logic          zero_c
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Count down and park at zero until the next load
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/truth_table_scanner.sv
// Automatic truth-table capture: steps abc_o through every input combination, waits
// SETTLE_CYCLES clocks, samples f_i into tt_o and counts minterms.
// Optional feature macro: TT_COMPARE_EN (adds expected_i / match_o / first_err_o).
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   start        : begin a scan (only honoured in IDLE)
//   abc_o        : function inputs, MSB = A
//   f_i          : function output F
//   busy         : scan in progress
//   done         : one-cycle completion pulse
//   tt_o         : captured table, tt_o[i] = F(i)
//   minterm_cnt  : number of ones in tt_o
//   expected_i   : reference table (TT_COMPARE_EN)
//   match_o      : tt_o == expected_i, valid from done (TT_COMPARE_EN)
//   first_err_o  : lowest mismatching index (TT_COMPARE_EN)
module truth_table_scanner
   import tt_scan_pkg::*;
#(
   parameter int unsigned N_IN          = DEF_N_IN,
   parameter int unsigned SETTLE_CYCLES = DEF_SETTLE
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   output logic [N_IN-1:0]           abc_o,
   input  logic                      f_i,
   output logic                      busy,
   output logic                      done,
   output logic [tt_depth(N_IN)-1:0] tt_o,
`ifdef TT_COMPARE_EN
   input  logic [tt_depth(N_IN)-1:0] expected_i,
   output logic                      match_o,
   output logic [N_IN-1:0]           first_err_o,
`endif
   output logic [N_IN:0]             minterm_cnt
);

   localparam int unsigned DEPTH = tt_depth(N_IN);
   localparam int unsigned CW    = $clog2(SETTLE_CYCLES) + 1;
   localparam int unsigned IW    = N_IN + 1;

   state_e            state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [N_IN-1:0]   abc_q, abc_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [DEPTH-1:0]  tt_q, tt_d;
   logic [N_IN:0]     cnt_q, cnt_d;
   logic              timer_load;
   logic              timer_zero_c;

`ifdef TT_COMPARE_EN
   logic              match_q, match_d;
   logic [N_IN-1:0]   ferr_q, ferr_d;
   logic [DEPTH-1:0]  diff_c;
   logic [N_IN-1:0]   ferr_c;

   // Lowest set bit of the mismatch vector; scanning downward lets the lowest win
   assign diff_c = tt_d ^ expected_i;
   always_comb begin
      ferr_c = '0;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         if (diff_c[i]) ferr_c = N_IN'(i);
      end
   end
`endif

   settle_timer #(.CW(CW)) u_settle_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (timer_load),
      .load_val (CW'(SETTLE_CYCLES - 1)),
      .zero_c   (timer_zero_c)
   );

   // Next-state and next-output logic
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      abc_d      = abc_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      tt_d       = tt_q;
      cnt_d      = cnt_q;
      timer_load = 1'b0;
`ifdef TT_COMPARE_EN
      match_d    = match_q;
      ferr_d     = ferr_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start) begin
               idx_d      = '0;
               abc_d      = '0;
               tt_d       = '0;
               cnt_d      = '0;
               busy_d     = 1'b1;
               timer_load = 1'b1;
               state_d    = SETTLE;
`ifdef TT_COMPARE_EN
               match_d    = 1'b0;
               ferr_d     = '0;
`endif
            end
         end
         SETTLE: begin
            if (timer_zero_c) state_d = SAMPLE;
         end
         SAMPLE: begin
            tt_d[idx_q[N_IN-1:0]] = f_i;
            cnt_d = cnt_q + IW'(f_i);
            if (idx_q == IW'(DEPTH - 1)) begin
               // Last entry: finish, return inputs to zero
               state_d = DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               abc_d   = '0;
`ifdef TT_COMPARE_EN
               match_d = (diff_c == '0);
               ferr_d  = ferr_c;
`endif
            end else begin
               idx_d      = idx_q + IW'(1);
               abc_d      = N_IN'(idx_q + IW'(1));
               timer_load = 1'b1;
               state_d    = SETTLE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         abc_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         tt_q    <= '0;
         cnt_q   <= '0;
`ifdef TT_COMPARE_EN
         match_q <= 1'b0;
         ferr_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         abc_q   <= abc_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         tt_q    <= tt_d;
         cnt_q   <= cnt_d;
`ifdef TT_COMPARE_EN
         match_q <= match_d;
         ferr_q  <= ferr_d;
`endif
      end
   end

   assign abc_o       = abc_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign tt_o        = tt_q;
   assign minterm_cnt = cnt_q;
`ifdef TT_COMPARE_EN
   assign match_o     = match_q;
   assign first_err_o = ferr_q;
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner: default instance (N_IN=3, SETTLE=2) plus a
// SETTLE_CYCLES=1 instance for abc_o sequencing.
module tb_truth_table_scanner;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start0 = 1'b0;
   logic       start1 = 1'b0;
   logic [2:0] abc0, abc1;
   logic       f0, f1;
   logic       busy0, busy1, done0, done1;
   logic [7:0] tt0, tt1;
   logic [3:0] cnt0, cnt1;
   int         fmode = 0;   // 0 = lab function, 1 = tied 0, 2 = tied 1
   int         passed = 0;
   int         total  = 0;
`ifdef TT_COMPARE_EN
   logic [7:0] exp0 = 8'h00;
   logic [7:0] exp1 = 8'h00;
   logic       match0, match1;
   logic [2:0] ferr0, ferr1;
`endif

   always #5 clk = ~clk;

   function automatic logic lab_f(input logic [2:0] v);
      return ~(v[2] ^ v[1]) | (v[2] & v[0]);
   endfunction

   always_comb begin
      f0 = (fmode == 1) ? 1'b0 : (fmode == 2) ? 1'b1 : lab_f(abc0);
      f1 = lab_f(abc1);
   end

   truth_table_scanner #(.N_IN(3), .SETTLE_CYCLES(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start0), .abc_o(abc0), .f_i(f0),
      .busy(busy0), .done(done0), .tt_o(tt0),
`ifdef TT_COMPARE_EN
      .expected_i(exp0), .match_o(match0), .first_err_o(ferr0),
`endif
      .minterm_cnt(cnt0)
   );

   truth_table_scanner #(.N_IN(3), .SETTLE_CYCLES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .abc_o(abc1), .f_i(f1),
      .busy(busy1), .done(done1), .tt_o(tt1),
`ifdef TT_COMPARE_EN
      .expected_i(exp1), .match_o(match1), .first_err_o(ferr1),
`endif
      .minterm_cnt(cnt1)
   );

   // Start pulse in cycle 0, optional re-pulses at cycles rp1/rp2; observe 40 cycles
   task automatic run_scan(input int rp1, input int rp2, output int done_cyc,
                           output int n_done, output logic b_first, output logic b_done);
      @(posedge clk); #1 start0 = 1'b1;
      @(posedge clk); #1 start0 = 1'b0;
      done_cyc = -1; n_done = 0; b_first = 1'bx; b_done = 1'bx;
      for (int c = 1; c <= 40; c++) begin
         start0 = (c == rp1) || (c == rp2);
         if (c == 1) b_first = busy0;
         if (done0 === 1'b1) begin
            n_done++;
            if (done_cyc < 0) begin
               done_cyc = c;
               b_done   = busy0;
            end
         end
         @(posedge clk); #1;
      end
      start0 = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++; if ({abc0, busy0, done0} !== 5'b0) $display("FAIL reset_ctl: got %b required 00000", {abc0, busy0, done0}); else passed++;
      total++; if (tt0 !== 8'h00) $display("FAIL reset_tt: got %h required 00", tt0); else passed++;
      total++; if (cnt0 !== 4'd0) $display("FAIL reset_cnt: got %0d required 0", cnt0); else passed++;
`ifdef TT_COMPARE_EN
      total++; if ({match0, ferr0} !== 4'b0) $display("FAIL reset_cmp: got %b required 0000", {match0, ferr0}); else passed++;
`endif
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_lab_function();
      int dc, nd; logic bf, bd;
      fmode = 0;
      run_scan(-1, -1, dc, nd, bf, bd);
      total++; if (dc != 25) $display("FAIL lab_done_cycle: got %0d required 25", dc); else passed++;
      total++; if (nd != 1) $display("FAIL lab_done_count: got %0d required 1", nd); else passed++;
      total++; if (bf !== 1'b1) $display("FAIL lab_busy_c1: got %b required 1", bf); else passed++;
      total++; if (bd !== 1'b0) $display("FAIL lab_busy_at_done: got %b required 0", bd); else passed++;
      total++; if (tt0 !== 8'hE3) $display("FAIL lab_tt: got %h required e3", tt0); else passed++;
      total++; if (cnt0 !== 4'd5) $display("FAIL lab_cnt: got %0d required 5", cnt0); else passed++;
      total++; if (abc0 !== 3'd0) $display("FAIL lab_abc_end: got %0d required 0", abc0); else passed++;
   endtask

   task automatic test_constant_f();
      int dc, nd; logic bf, bd;
      fmode = 1;
      run_scan(-1, -1, dc, nd, bf, bd);
      total++; if (tt0 !== 8'h00) $display("FAIL zero_tt: got %h required 00", tt0); else passed++;
      total++; if (cnt0 !== 4'd0) $display("FAIL zero_cnt: got %0d required 0", cnt0); else passed++;
      fmode = 2;
      run_scan(-1, -1, dc, nd, bf, bd);
      total++; if (tt0 !== 8'hFF) $display("FAIL ones_tt: got %h required ff", tt0); else passed++;
      total++; if (cnt0 !== 4'd8) $display("FAIL ones_cnt: got %0d required 8", cnt0); else passed++;
      total++; if (dc != 25) $display("FAIL ones_done_cycle: got %0d required 25", dc); else passed++;
      fmode = 0;
   endtask

   // SETTLE_CYCLES=1: abc_o = k during cycles 2k+1 and 2k+2, done at 17
   task automatic test_abc_sequence();
      int dc = -1;
      int bad = 0;
      @(posedge clk); #1 start1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         if (c <= 16 && abc1 !== 3'((c - 1) / 2)) begin
            if (bad == 0) $display("FAIL seq_abc: cycle %0d got %0d required %0d", c, abc1, (c - 1) / 2);
            bad++;
         end
         if (done1 === 1'b1 && dc < 0) dc = c;
         @(posedge clk); #1;
      end
      total++; if (bad != 0) $display("FAIL seq_abc_total: got %0d bad cycles required 0", bad); else passed++;
      total++; if (dc != 17) $display("FAIL seq_done_cycle: got %0d required 17", dc); else passed++;
      total++; if (tt1 !== 8'hE3) $display("FAIL seq_tt: got %h required e3", tt1); else passed++;
   endtask

   task automatic test_start_while_busy();
      int dc, nd; logic bf, bd;
      fmode = 0;
      run_scan(5, 12, dc, nd, bf, bd);
      total++; if (dc != 25) $display("FAIL rp_done_cycle: got %0d required 25", dc); else passed++;
      total++; if (nd != 1) $display("FAIL rp_done_count: got %0d required 1", nd); else passed++;
      total++; if (tt0 !== 8'hE3) $display("FAIL rp_tt: got %h required e3", tt0); else passed++;
   endtask

   task automatic test_reset_mid_scan();
      int nd = 0;
      int dc; logic bf, bd;
      fmode = 0;
      @(posedge clk); #1 start0 = 1'b1;
      @(posedge clk); #1 start0 = 1'b0;
      for (int c = 1; c < 10; c++) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      total++; if ({abc0, busy0, done0} !== 5'b0) $display("FAIL midrst_ctl: got %b required 00000", {abc0, busy0, done0}); else passed++;
      total++; if ({tt0, cnt0} !== 12'h000) $display("FAIL midrst_data: got %h required 000", {tt0, cnt0}); else passed++;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
      end
      @(negedge clk) rst_n = 1'b1;
      for (int c = 0; c < 30; c++) begin
         if (done0 === 1'b1) nd++;
         @(posedge clk); #1;
      end
      total++; if (nd != 0) $display("FAIL midrst_no_done: got %0d required 0", nd); else passed++;
      run_scan(-1, -1, dc, nd, bf, bd);
      total++; if (dc != 25 || tt0 !== 8'hE3 || cnt0 !== 4'd5)
         $display("FAIL midrst_rescan: got cyc %0d tt %h cnt %0d required 25 e3 5", dc, tt0, cnt0);
      else passed++;
   endtask

`ifdef TT_COMPARE_EN
   task automatic test_compare();
      int dc, nd; logic bf, bd;
      fmode = 0;
      exp0 = 8'hE3;
      run_scan(-1, -1, dc, nd, bf, bd);
      total++; if (match0 !== 1'b1) $display("FAIL cmp_match: got %b required 1", match0); else passed++;
      total++; if (ferr0 !== 3'd0) $display("FAIL cmp_ferr0: got %0d required 0", ferr0); else passed++;
      exp0 = 8'hE7;
      run_scan(-1, -1, dc, nd, bf, bd);
      total++; if (match0 !== 1'b0) $display("FAIL cmp_mismatch: got %b required 0", match0); else passed++;
      total++; if (ferr0 !== 3'd2) $display("FAIL cmp_ferr2: got %0d required 2", ferr0); else passed++;
   endtask
`endif

   initial begin
      test_reset();
      test_lab_function();
      test_constant_f();
      test_abc_sequence();
      test_start_while_busy();
      test_reset_mid_scan();
`ifdef TT_COMPARE_EN
      test_compare();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
